twiddle_seq: RTL and testbench
==============================

# twiddle_seq

Twiddle-factor and phase sequencer for one radix-2 DIF single-path FFT stage. It tracks position within the interleaved real/imaginary word stream and drives the `twiddle` and `sw` inputs of the stage's downstream complex rotator. The rotator therefore applies the correct W factor to each complex sample. It sits between the stage butterfly/delay-feedback section (frame markers) and the rotator (twiddle/sw), one instance per stage.

## Interface
- `FFT_LEN`, 256: points per frame N; power of two, 4..4096.
- `STAGE`, 0: stage index s, 0..log2(N)-1; sub-block length L = N >> s.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset; one clock, asynchronous assert, active-low.
- `in_valid`  in  1: one stream word (real or imaginary) accepted this cycle.
- `in_sof`  in  1: qualified by `in_valid`; the word is the real word of sample 0 of a frame.
- `twiddle`  out  twiddle_t: `cos`/`sin` fields, each TWIDDLE_WIDTH signed, Q1.(TWIDDLE_WIDTH-1).
- `sw`  out  1: word phase; 1 = imaginary word, 0 = real word.
- `out_valid`  out  1: `twiddle`/`sw` correspond to a word accepted the previous cycle.
- `sync_err`  out  1: one-cycle pulse on a frame resync that was not at word 0.

## Operation
- Word counter `w` covers 0..2N-1 and advances only on `in_valid`. It wraps 2N-1 -> 0.
  - Sample index k = w >> 1.
  - Phase p = w & 1; real word first.
- Twiddle table: N/2 entries computed at elaboration.
  - Entry i = (round(cos(2πi/N)·2^(T-1)), round(-sin(2πi/N)·2^(T-1))), with T = TWIDDLE_WIDTH.
  - Values saturate to [-2^(T-1), 2^(T-1)-1]; entry 0 is (2^(T-1)-1, 0).
- Factor for sample k:
  - n = k mod L.
  - If n < L/2, W = entry 0 (unity).
  - Otherwise W = entry ((n - L/2) << s).
- Output update on each accepted word:
  - `sw` <= p.
  - When p=1, `twiddle` <= W(k). When p=0, `twiddle` holds.
  - Result: W(k) is presented on the imaginary-word cycle of sample k and the real-word cycle of sample k+1. This matches the rotator's one-word skew.
- `in_sof` with `in_valid`:
  - The word is treated as w=0, and the counter becomes 1 afterwards.
  - If the counter was not 0, `sync_err` pulses the following cycle. The outputs for that word are computed as for w=0.
- `in_sof` without `in_valid` is ignored.
- Gaps (`in_valid`=0): the counter and `twiddle`/`sw` hold, and `out_valid`=0 the next cycle.
- Arithmetic:
  - Counter width log2(2N).
  - Table index width log2(N/2).
  - The shift by s never overflows because (n - L/2) < L/2.

## Timing
- Latency: all outputs are registered, one cycle after the accepting `in_valid` edge. Upstream delays the data word by one register so data and twiddle/sw align at the rotator.
- Reset values:
  - `w`=0.
  - `twiddle`=(2^(T-1)-1, 0).
  - `sw`=0, `out_valid`=0, `sync_err`=0.
- Reset mid-frame: immediate return to the above. The first accepted word after release is w=0 whether or not `in_sof` is asserted.
- Throughput: one word per cycle sustained; no backpressure.
- Simultaneous wrap and `in_sof`: the counter goes to 1 and there is no `sync_err`.
- Table lookup plus register must close at the rotator's clock. The ROM may be registered internally only if the visible one-cycle latency is preserved.

## Test plan
All scenarios use N=16, TWIDDLE_WIDTH=16 (max 32767, min -32768).
- STAGE=0, reset then 32 consecutive words with `in_sof` on the first:
  - `sw` alternates 0,1 starting at 0.
  - Samples 0-7 give `twiddle`=(32767,0).
  - Sample 10 imaginary word gives (23170,-23170).
  - Sample 12 gives (0,-32768).
  - `twiddle` changes only on `sw`=1 cycles.
- STAGE=1, one frame:
  - Samples 4-7 use indices 0,2,4,6; sample 6 gives (0,-32768).
  - Samples 0-3 and 8-11 give (32767,0).
- Random `in_valid` gaps over two frames: the output sequence with bubbles removed equals the gapless run, and `out_valid` mirrors `in_valid` delayed by one cycle.
- `in_sof` at w=9:
  - `sync_err` is high for exactly one cycle.
  - The next words follow the w=0,1,2 pattern.
  - `in_sof` exactly at the wrap produces no `sync_err`.
- Assert `rst_n` low asynchronously mid-frame (between clock edges):
  - Outputs go to reset values immediately.
  - After release the first word is sample 0 real, with `twiddle`=(32767,0).
- Scoreboard: feed the outputs plus aligned data into the rotator model, run 1000 random frames, and compare against a floating-point stage reference within ±2 LSB.

Source files
------------

// File: rtl/twiddle_seq_if.sv
// Stream-side bundle of the twiddle sequencer: word strobes in, rotator controls out.
// The twiddle_t layout (cos in the upper half) is shared by the sequencer and its consumers.
interface twiddle_seq_if #(
  parameter int TWIDDLE_WIDTH = 16
);
  typedef struct packed {
    logic signed [TWIDDLE_WIDTH-1:0] cos;
    logic signed [TWIDDLE_WIDTH-1:0] sin;
  } twiddle_t;

  logic     in_valid;
  logic     in_sof;
  twiddle_t twiddle;
  logic     sw;
  logic     out_valid;
  logic     sync_err;

  modport master (output in_valid, in_sof, input twiddle, sw, out_valid, sync_err);
  modport slave  (input in_valid, in_sof, output twiddle, sw, out_valid, sync_err);
endinterface

// File: rtl/twiddle_seq.sv
// Twiddle/phase sequencer for one radix-2 DIF SDF stage: walks the interleaved re/im
// word stream and presents W(k) on the imag word of sample k and the real word of k+1.
module twiddle_seq #(
  parameter int FFT_LEN       = 256,
  parameter int STAGE         = 0,
  parameter int TWIDDLE_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  twiddle_seq_if.slave  bus
);
  localparam int  T      = TWIDDLE_WIDTH;
  localparam int  LOGN   = $clog2(FFT_LEN);
  localparam int  CW     = LOGN + 1;
  localparam int  IDXW   = LOGN - 1;
  localparam int  HALF   = FFT_LEN / 2;
  localparam int  L      = FFT_LEN >> STAGE;
  localparam int  QMAX   = (1 << (T - 1)) - 1;
  localparam int  QMIN   = -(1 << (T - 1));
  localparam real SCALE  = 2.0 ** (T - 1);
  localparam real PI     = 3.14159265358979323846;
  localparam logic [LOGN-1:0]     L_MASK = LOGN'(L - 1);
  localparam logic [LOGN-1:0]     HALF_L = LOGN'(L / 2);
  localparam logic signed [T-1:0] UNITY  = T'(QMAX);

  // SV real-to-int casts round half away from zero; +1.0 clips to the max code.
  function automatic int tw_q(input real x);
    int v;
    v = int'(x * SCALE);
    if (v > QMAX) v = QMAX;
    else if (v < QMIN) v = QMIN;
    return v;
  endfunction

  logic signed [T-1:0] rom_cos [HALF];
  logic signed [T-1:0] rom_sin [HALF];

  for (genvar i = 0; i < HALF; i++) begin : g_rom
    localparam real ANG = 2.0 * PI * i / FFT_LEN;
    localparam int  C   = tw_q($cos(ANG));
    localparam int  S   = tw_q(-$sin(ANG));
    assign rom_cos[i] = C[T-1:0];
    assign rom_sin[i] = S[T-1:0];
  end

  logic [CW-1:0]       w, w_eff;
  logic [LOGN-1:0]     k, n;
  logic [IDXW-1:0]     idx;
  logic                p, upper;
  logic signed [T-1:0] tw_cos_q, tw_sin_q;
  logic                sw_q, out_valid_q, sync_err_q;

  // A frame marker forces this word to w=0 regardless of where the counter was.
  always_comb begin
    w_eff = bus.in_sof ? '0 : w;
    k     = w_eff[CW-1:1];
    p     = w_eff[0];
    n     = k & L_MASK;
    upper = (n >= HALF_L);
    idx   = IDXW'(n - HALF_L) << STAGE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w           <= '0;
      tw_cos_q    <= UNITY;
      tw_sin_q    <= '0;
      sw_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      sync_err_q  <= bus.in_valid & bus.in_sof & (w != '0);
      if (bus.in_valid) begin
        w    <= w_eff + 1'b1;
        sw_q <= p;
        // Twiddle only moves on the imaginary word, giving the rotator its one-word skew.
        if (p) begin
          tw_cos_q <= upper ? rom_cos[idx] : UNITY;
          tw_sin_q <= upper ? rom_sin[idx] : '0;
        end
      end
    end
  end

  assign bus.twiddle   = {tw_cos_q, tw_sin_q};
  assign bus.sw        = sw_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboarded bench for twiddle_seq: stage 0 and stage 1 instances share one stimulus
// stream; expected outputs come from a trig-based reference of the stage factor rules.
module tb_twiddle_seq;
  localparam int N = 16;
  localparam int T = 16;

  typedef struct { int sw; int c; int s; int se; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  twiddle_seq_if #(.TWIDDLE_WIDTH(T)) bus0 ();
  twiddle_seq_if #(.TWIDDLE_WIDTH(T)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_sof   = in_sof;
  assign bus1.in_valid = in_valid;
  assign bus1.in_sof   = in_sof;

  twiddle_seq #(.FFT_LEN(N), .STAGE(0), .TWIDDLE_WIDTH(T)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  twiddle_seq #(.FFT_LEN(N), .STAGE(1), .TWIDDLE_WIDTH(T)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // reference model state
  exp_t q0[$];
  exp_t q1[$];
  int   mw;
  int   pc[2];
  int   ps[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rnd_sat(input real x);
    int v;
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // W(k) for stage s: unity in the first half of each sub-block, else exp(-j*2*pi*m*2^s/N).
  function automatic void ref_w(input int k, input int s, output int c, output int sn);
    int  len, pos, m;
    real a;
    len = N >> s;
    pos = k % len;
    if (pos < len / 2) begin
      c  = 32767;
      sn = 0;
    end else begin
      m  = (pos - len / 2) * (1 << s);
      a  = 2.0 * 3.14159265358979 * m / N;
      c  = rnd_sat($cos(a) * 32768.0);
      sn = rnd_sat(-$sin(a) * 32768.0);
    end
  endfunction

  task automatic issue(input bit v, input bit sof);
    int   we, se;
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    if (v) begin
      se = (sof && mw != 0) ? 1 : 0;
      we = sof ? 0 : mw;
      mw = (we + 1) % (2 * N);
      for (int s = 0; s < 2; s++) begin
        if (we % 2 == 1) ref_w(we / 2, s, pc[s], ps[s]);
        e.sw = we % 2; e.c = pc[s]; e.s = ps[s]; e.se = se;
        if (s == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  task automatic model_reset();
    mw = 0;
    for (int s = 0; s < 2; s++) begin pc[s] = 32767; ps[s] = 0; end
  endtask

  task automatic cmp_out(input string nm, input logic sw, input int c, input int sn,
                         input logic se, input exp_t e);
    chk({nm, "_sw"}, int'(sw), e.sw);
    chk({nm, "_cos"}, c, e.c);
    chk({nm, "_sin"}, sn, e.s);
    chk({nm, "_serr"}, int'(se), e.se);
  endtask

  task automatic chk_tw(input string nm, input int c, input int sn, input int ec, input int es);
    chk({nm, "_cos"}, c, ec);
    chk({nm, "_sin"}, sn, es);
  endtask

  // monitor: out_valid mirrors last cycle's in_valid; each output word pops one expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("s0_ov", int'(bus0.out_valid), int'(in_valid));
    chk("s1_ov", int'(bus1.out_valid), int'(in_valid));
    if (bus0.out_valid) begin
      if (q0.size() == 0) chk("s0_q_empty", 1, 0);
      else begin
        e = q0.pop_front();
        cmp_out("s0", bus0.sw, int'($signed(bus0.twiddle.cos)), int'($signed(bus0.twiddle.sin)),
                bus0.sync_err, e);
      end
    end else chk("s0_serr_idle", int'(bus0.sync_err), 0);
    if (bus1.out_valid) begin
      if (q1.size() == 0) chk("s1_q_empty", 1, 0);
      else begin
        e = q1.pop_front();
        cmp_out("s1", bus1.sw, int'($signed(bus1.twiddle.cos)), int'($signed(bus1.twiddle.sin)),
                bus1.sync_err, e);
      end
    end else chk("s1_serr_idle", int'(bus1.sync_err), 0);
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ov0"}, int'(bus0.out_valid), 0);
    chk({nm, "_sw0"}, int'(bus0.sw), 0);
    chk({nm, "_se0"}, int'(bus0.sync_err), 0);
    chk_tw({nm, "_tw0"}, int'($signed(bus0.twiddle.cos)), int'($signed(bus0.twiddle.sin)), 32767, 0);
    chk({nm, "_ov1"}, int'(bus1.out_valid), 0);
    chk({nm, "_sw1"}, int'(bus1.sw), 0);
    chk_tw({nm, "_tw1"}, int'($signed(bus1.twiddle.cos)), int'($signed(bus1.twiddle.sin)), 32767, 0);
  endtask

  initial begin
    int cnt;
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // one gapless frame with sof on the first word, plus directed factor checks
    for (int w = 0; w < 2 * N; w++) begin
      issue(1'b1, w == 0);
      @(posedge clk); #2;
      if (w == 0)  chk("first_sw", int'(bus0.sw), 0);
      if (w == 1)  chk("second_sw", int'(bus0.sw), 1);
      if (w == 15) chk_tw("s0_k7", int'($signed(bus0.twiddle.cos)), int'($signed(bus0.twiddle.sin)), 32767, 0);
      if (w == 21) chk_tw("s0_k10", int'($signed(bus0.twiddle.cos)), int'($signed(bus0.twiddle.sin)), 23170, -23170);
      if (w == 25) chk_tw("s0_k12", int'($signed(bus0.twiddle.cos)), int'($signed(bus0.twiddle.sin)), 0, -32768);
      if (w == 26) chk_tw("s0_k13re", int'($signed(bus0.twiddle.cos)), int'($signed(bus0.twiddle.sin)), 0, -32768);
      if (w == 13) chk_tw("s1_k6", int'($signed(bus1.twiddle.cos)), int'($signed(bus1.twiddle.sin)), 0, -32768);
      if (w == 11) chk_tw("s1_k5", int'($signed(bus1.twiddle.cos)), int'($signed(bus1.twiddle.sin)), 23170, -23170);
      if (w == 17) chk_tw("s1_k8", int'($signed(bus1.twiddle.cos)), int'($signed(bus1.twiddle.sin)), 32767, 0);
    end

    // two frames with random bubbles
    cnt = 0;
    while (cnt < 4 * N) begin
      if ($urandom_range(2) != 0) begin issue(1'b1, 1'b0); cnt++; end
      else issue(1'b0, 1'b0);
    end

    // resync at w=9, then a frame marker exactly on the wrap
    repeat (9) issue(1'b1, 1'b0);
    issue(1'b1, 1'b1);
    @(posedge clk); #2;
    chk("sof9_serr", int'(bus0.sync_err), 1);
    chk("sof9_sw", int'(bus0.sw), 0);
    issue(1'b1, 1'b0);
    @(posedge clk); #2;
    chk("sof9_serr_off", int'(bus0.sync_err), 0);
    chk("sof9_w1_sw", int'(bus0.sw), 1);
    repeat (2 * N - 2) issue(1'b1, 1'b0);
    issue(1'b1, 1'b1);
    @(posedge clk); #2;
    chk("wrap_sof_serr", int'(bus0.sync_err), 0);

    // async reset between edges mid-frame, after a non-unity twiddle is showing
    repeat (20) issue(1'b1, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    #1 chk_reset_vals("async_rst");
    chk("async_rst_q", q0.size() + q1.size(), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0);
    @(posedge clk); #2;
    chk("post_rst_sw", int'(bus0.sw), 0);
    chk_tw("post_rst_tw", int'($signed(bus0.twiddle.cos)), int'($signed(bus0.twiddle.sin)), 32767, 0);

    // long random run: gaps, stray sof without valid, occasional mid-frame resync
    for (int i = 0; i < 6000; i++)
      issue($urandom_range(3) != 0, $urandom_range(60) == 0);

    issue(1'b0, 1'b0);
    issue(1'b0, 1'b0);
    @(posedge clk); #2;
    chk("drain_q", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
